mips_data_memory: RTL and testbench

Memory responder at the far end of the `mips_core` instruction and data buses. It serves 32-bit instruction fetches and 64-bit byte-masked data loads and stores, both with a fixed one-cycle read latency. After every reset it zero-fills the array under a small state machine. It flags out-of-range accesses through a sticky error bit. Port names match the core's bus so the two blocks connect name-to-name; direction is from this block's view.

---
 rtl/mips_mem_pkg.sv | 29 ++
 rtl/mips_data_memory_if.sv | 34 +++
 rtl/mips_mem_bank.sv | 49 ++++
 rtl/mips_data_memory.sv | 127 ++++++++++++
 tb/tb_mips_data_memory.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and address helpers for the MIPS data memory.
//   mem_state_t   : clear/ready state of the post-reset zero-fill machine
//   WORD_BYTES    : bytes per storage word
//   addr_to_index : byte address -> word index relative to a base
//   addr_in_range : true when an address maps onto an existing word
package mips_mem_pkg;

    typedef enum logic [0:0] {
        CLEAR,
        READY
    } mem_state_t;

    localparam int unsigned WORD_BYTES = 8;
    localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

    function automatic logic [63:0] addr_to_index(input logic [63:0] addr,
                                                  input logic [63:0] base);
        return (addr - base) >> WORD_SHIFT;
    endfunction

    // The explicit base compare keeps addresses below the base from wrapping
    // into range through the 64-bit subtraction.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] depth);
        return (addr >= base) && (addr_to_index(addr, base) < depth);
    endfunction

endpackage

// File: rtl/mips_data_memory_if.sv
// mips_data_memory_if: instruction and data bus between mips_core and its memory.
//   data_address/data_out/data_mask/data_read/data_write : data request from core
//   data_in                                              : load data to core
//   instr_address/instr_read                             : fetch request from core
//   instr_in                                             : fetched instruction
//   busy/bus_error                                       : memory status
// Modport master is the core side, slave is the memory side.
interface mips_data_memory_if;

    logic [63:0] data_address;
    logic [63:0] data_out;
    logic [7:0]  data_mask;
    logic        data_read;
    logic        data_write;
    logic [63:0] data_in;
    logic [63:0] instr_address;
    logic        instr_read;
    logic [31:0] instr_in;
    logic        busy;
    logic        bus_error;

    modport master (
        output data_address, data_out, data_mask, data_read, data_write,
        output instr_address, instr_read,
        input  data_in, instr_in, busy, bus_error
    );

    modport slave (
        input  data_address, data_out, data_mask, data_read, data_write,
        input  instr_address, instr_read,
        output data_in, instr_in, busy, bus_error
    );

endinterface

// File: rtl/mips_mem_bank.sv
// mips_mem_bank: storage array of DEPTH_WORDS 64-bit words.
//   clk                    : clock
//   we_i/waddr_i/wdata_i/wbe_i : write port with per-byte enables
//   rd_a_en_i/rd_a_addr_i/rd_a_data_o : synchronous read port A
//   rd_b_en_i/rd_b_addr_i/rd_b_data_o : synchronous read port B
// Read data registers hold when their enable is low. Reads return the
// contents from before a same-edge write.
module mips_mem_bank #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [63:0]   wdata_i,
    input  logic [7:0]    wbe_i,
    input  logic          rd_a_en_i,
    input  logic [AW-1:0] rd_a_addr_i,
    output logic [63:0]   rd_a_data_o,
    input  logic          rd_b_en_i,
    input  logic [AW-1:0] rd_b_addr_i,
    output logic [63:0]   rd_b_data_o
);

    logic [63:0] mem_q [DEPTH_WORDS];
    logic [63:0] rd_a_q;
    logic [63:0] rd_b_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (we_i && wbe_i[i]) begin
                mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_a_en_i) begin
            rd_a_q <= mem_q[rd_a_addr_i];
        end
        if (rd_b_en_i) begin
            rd_b_q <= mem_q[rd_b_addr_i];
        end
    end

    assign rd_a_data_o = rd_a_q;
    assign rd_b_data_o = rd_b_q;

endmodule

// File: rtl/mips_data_memory.sv
// mips_data_memory: memory responder for the mips_core instruction/data buses.
//   clk   : clock
//   reset : synchronous active-high reset; restarts the zero-fill
//   bus   : slave side of mips_data_memory_if (loads, stores, fetches, status)
// After reset the array is zero-filled one word per cycle (busy high), then
// requests are served with a one-cycle read latency. Out-of-range accesses
// return zero, drop stores and set the sticky bus_error.
module mips_data_memory
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic                clk,
    input  logic                reset,
    mips_data_memory_if.slave   bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    mem_state_t    state_q;
    logic [AW-1:0] clear_ptr_q;
    logic          bus_error_q;
    // Output zero-selects: set on reset or an out-of-range read, cleared by a
    // valid read. They hold with the bank registers so idle cycles keep data.
    logic          data_zero_q;
    logic          instr_zero_q;
    logic          instr_hi_q;

    logic          ready;
    logic          data_ok;
    logic          instr_ok;
    logic [AW-1:0] data_idx;
    logic [AW-1:0] instr_idx;

    logic          bank_we;
    logic [AW-1:0] bank_waddr;
    logic [63:0]   bank_wdata;
    logic [7:0]    bank_wbe;
    logic          data_rd_en;
    logic          instr_rd_en;
    logic [63:0]   data_word;
    logic [63:0]   instr_word;

    assign ready     = (state_q == READY);
    assign data_ok   = addr_in_range(bus.data_address, BASE_ADDR, 64'(DEPTH_WORDS));
    assign instr_ok  = addr_in_range(bus.instr_address, BASE_ADDR, 64'(DEPTH_WORDS));
    assign data_idx  = AW'(addr_to_index(bus.data_address, BASE_ADDR));
    assign instr_idx = AW'(addr_to_index(bus.instr_address, BASE_ADDR));

    assign data_rd_en  = ready && bus.data_read && data_ok;
    assign instr_rd_en = ready && bus.instr_read && instr_ok;

    // The clear machine owns the write port while not ready.
    always_comb begin
        bank_we    = 1'b0;
        bank_waddr = data_idx;
        bank_wdata = bus.data_out;
        bank_wbe   = bus.data_mask;
        if (!ready) begin
            bank_we    = 1'b1;
            bank_waddr = clear_ptr_q;
            bank_wdata = '0;
            bank_wbe   = 8'hFF;
        end else if (bus.data_write && data_ok) begin
            bank_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR;
            clear_ptr_q  <= '0;
            bus_error_q  <= 1'b0;
            data_zero_q  <= 1'b1;
            instr_zero_q <= 1'b1;
            instr_hi_q   <= 1'b0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    clear_ptr_q <= clear_ptr_q + 1'b1;
                    if (clear_ptr_q == LAST_IDX) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    if (bus.data_read) begin
                        data_zero_q <= !data_ok;
                    end
                    if (bus.instr_read) begin
                        instr_zero_q <= !instr_ok;
                        instr_hi_q   <= bus.instr_address[2];
                    end
                    if (((bus.data_read || bus.data_write) && !data_ok) ||
                        (bus.instr_read && !instr_ok)) begin
                        bus_error_q <= 1'b1;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    mips_mem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk         (clk),
        .we_i        (bank_we),
        .waddr_i     (bank_waddr),
        .wdata_i     (bank_wdata),
        .wbe_i       (bank_wbe),
        .rd_a_en_i   (data_rd_en),
        .rd_a_addr_i (data_idx),
        .rd_a_data_o (data_word),
        .rd_b_en_i   (instr_rd_en),
        .rd_b_addr_i (instr_idx),
        .rd_b_data_o (instr_word)
    );

    assign bus.data_in   = data_zero_q ? 64'h0 : data_word;
    assign bus.instr_in  = instr_zero_q ? 32'h0 :
                           (instr_hi_q ? instr_word[63:32] : instr_word[31:0]);
    assign bus.busy      = (state_q == CLEAR);
    assign bus.bus_error = bus_error_q;

endmodule

// File: tb/tb_mips_data_memory.sv
// tb_mips_data_memory: directed self-checking bench for mips_data_memory.
// Inputs change on the falling edge; outputs are sampled one falling edge later.
module tb_mips_data_memory;

    localparam int unsigned DEPTH = 16;
    localparam logic [63:0] BASE  = 64'h1000;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mips_data_memory_if bus ();

    mips_data_memory #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.data_address  = '0;
        bus.data_out      = '0;
        bus.data_mask     = '0;
        bus.data_read     = 1'b0;
        bus.data_write    = 1'b0;
        bus.instr_address = '0;
        bus.instr_read    = 1'b0;
    endtask

    task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
        bus.data_address = a;
        bus.data_out     = d;
        bus.data_mask    = m;
        bus.data_write   = 1'b1;
        step();
        bus.data_write   = 1'b0;
    endtask

    task automatic do_load(input logic [63:0] a);
        bus.data_address = a;
        bus.data_read    = 1'b1;
        step();
        bus.data_read    = 1'b0;
    endtask

    task automatic do_fetch(input logic [63:0] a);
        bus.instr_address = a;
        bus.instr_read    = 1'b1;
        step();
        bus.instr_read    = 1'b0;
    endtask

    // Bounded: a stuck busy ends the loop at DEPTH+8, which fails the count check.
    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy && n < int'(DEPTH) + 8) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.data_in !== 64'h0) begin n_bad++; $display("FAIL reset_data_in: got %h want 0", bus.data_in); end
        n_cmp++; if (bus.instr_in !== 32'h0) begin n_bad++; $display("FAIL reset_instr_in: got %h want 0", bus.instr_in); end
        n_cmp++; if (bus.bus_error !== 1'b0) begin n_bad++; $display("FAIL reset_bus_error: got %b want 0", bus.bus_error); end
        count_busy(n);
        n_cmp++; if (n != int'(DEPTH)) begin n_bad++; $display("FAIL busy_cycles: got %0d want %0d", n, DEPTH); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL busy_fall: got %b want 0", bus.busy); end
        do_load(BASE + 64'h8);
        n_cmp++; if (bus.data_in !== 64'h0) begin n_bad++; $display("FAIL load_cleared: got %h want 0", bus.data_in); end
    endtask

    task automatic test_byte_mask();
        do_store(BASE + 64'h10, 64'h1122334455667788, 8'hFF);
        do_store(BASE + 64'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        do_load(BASE + 64'h10);
        n_cmp++; if (bus.data_in !== 64'h11223344AAAAAAAA) begin n_bad++; $display("FAIL mask_0f: got %h want 11223344aaaaaaaa", bus.data_in); end
        do_store(BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        do_load(BASE + 64'h10);
        n_cmp++; if (bus.data_in !== 64'h11223344AAAAAAAA) begin n_bad++; $display("FAIL mask_zero: got %h want 11223344aaaaaaaa", bus.data_in); end
        do_store(BASE + 64'h18, 64'h0102030405060708, 8'hFF);
        do_store(BASE + 64'h1F, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81);
        do_load(BASE + 64'h18);
        n_cmp++; if (bus.data_in !== 64'hFF020304050607FF) begin n_bad++; $display("FAIL mask_81: got %h want ff020304050607ff", bus.data_in); end
    endtask

    task automatic test_fetch();
        do_fetch(BASE + 64'h10);
        n_cmp++; if (bus.instr_in !== 32'hAAAAAAAA) begin n_bad++; $display("FAIL fetch_lo: got %h want aaaaaaaa", bus.instr_in); end
        do_fetch(BASE + 64'h14);
        n_cmp++; if (bus.instr_in !== 32'h11223344) begin n_bad++; $display("FAIL fetch_hi: got %h want 11223344", bus.instr_in); end
        step();
        n_cmp++; if (bus.instr_in !== 32'h11223344) begin n_bad++; $display("FAIL instr_hold: got %h want 11223344", bus.instr_in); end
        n_cmp++; if (bus.data_in !== 64'hFF020304050607FF) begin n_bad++; $display("FAIL data_hold: got %h want ff020304050607ff", bus.data_in); end
        do_fetch(BASE + 64'h18);
        n_cmp++; if (bus.instr_in !== 32'h050607FF) begin n_bad++; $display("FAIL fetch_w3_lo: got %h want 050607ff", bus.instr_in); end
        do_fetch(BASE + 64'h1E);
        n_cmp++; if (bus.instr_in !== 32'hFF020304) begin n_bad++; $display("FAIL fetch_w3_hi: got %h want ff020304", bus.instr_in); end
    endtask

    task automatic test_back_to_back();
        bus.data_address  = BASE + 64'h10;
        bus.data_out      = 64'h0;
        bus.data_mask     = 8'hFF;
        bus.data_read     = 1'b1;
        bus.data_write    = 1'b1;
        bus.instr_address = BASE + 64'h10;
        bus.instr_read    = 1'b1;
        step();
        bus.data_write    = 1'b0;
        bus.instr_read    = 1'b0;
        n_cmp++; if (bus.data_in !== 64'h11223344AAAAAAAA) begin n_bad++; $display("FAIL rbw_load: got %h want 11223344aaaaaaaa", bus.data_in); end
        n_cmp++; if (bus.instr_in !== 32'hAAAAAAAA) begin n_bad++; $display("FAIL rbw_fetch: got %h want aaaaaaaa", bus.instr_in); end
        step();
        bus.data_read     = 1'b0;
        n_cmp++; if (bus.data_in !== 64'h0) begin n_bad++; $display("FAIL after_rbw: got %h want 0", bus.data_in); end
        do_store(BASE + 64'h28, 64'h0123456789ABCDEF, 8'hFF);
        do_load(BASE + 64'h28);
        n_cmp++; if (bus.data_in !== 64'h0123456789ABCDEF) begin n_bad++; $display("FAIL store_then_load: got %h want 0123456789abcdef", bus.data_in); end
        bus.data_address  = BASE + 64'h18;
        bus.data_read     = 1'b1;
        bus.instr_address = BASE + 64'h2C;
        bus.instr_read    = 1'b1;
        step();
        idle();
        n_cmp++; if (bus.data_in !== 64'hFF020304050607FF) begin n_bad++; $display("FAIL dual_load: got %h want ff020304050607ff", bus.data_in); end
        n_cmp++; if (bus.instr_in !== 32'h01234567) begin n_bad++; $display("FAIL dual_fetch: got %h want 01234567", bus.instr_in); end
    endtask

    task automatic test_out_of_range();
        n_cmp++; if (bus.bus_error !== 1'b0) begin n_bad++; $display("FAIL err_before: got %b want 0", bus.bus_error); end
        do_load(BASE + 64'(DEPTH) * 64'h8);
        n_cmp++; if (bus.data_in !== 64'h0) begin n_bad++; $display("FAIL oor_load: got %h want 0", bus.data_in); end
        n_cmp++; if (bus.bus_error !== 1'b1) begin n_bad++; $display("FAIL oor_err: got %b want 1", bus.bus_error); end
        do_store(BASE + 64'(DEPTH) * 64'h8, 64'hDEAD_BEEF_0000_0001, 8'hFF);
        do_load(BASE);
        n_cmp++; if (bus.data_in !== 64'h0) begin n_bad++; $display("FAIL oor_store_alias: got %h want 0", bus.data_in); end
        do_fetch(BASE + 64'h18);
        do_fetch(BASE + 64'(DEPTH) * 64'h8 + 64'h4);
        n_cmp++; if (bus.instr_in !== 32'h0) begin n_bad++; $display("FAIL oor_fetch: got %h want 0", bus.instr_in); end
        n_cmp++; if (bus.bus_error !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", bus.bus_error); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        do_load(BASE + 64'h18);
        do_fetch(BASE + 64'h28);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (bus.data_in !== 64'h0) begin n_bad++; $display("FAIL rst_data_in: got %h want 0", bus.data_in); end
        n_cmp++; if (bus.instr_in !== 32'h0) begin n_bad++; $display("FAIL rst_instr_in: got %h want 0", bus.instr_in); end
        n_cmp++; if (bus.bus_error !== 1'b0) begin n_bad++; $display("FAIL rst_err_clear: got %b want 0", bus.bus_error); end
        for (int i = 0; i < 4; i++) begin
            bus.data_address  = BASE + 64'(DEPTH) * 64'h8;
            bus.data_out      = 64'hFFFF_FFFF_FFFF_FFFF;
            bus.data_mask     = 8'hFF;
            bus.data_read     = 1'b1;
            bus.data_write    = 1'b1;
            bus.instr_address = BASE + 64'h28;
            bus.instr_read    = 1'b1;
            step();
            n_cmp++; if (bus.data_in !== 64'h0) begin n_bad++; $display("FAIL clear_data_in[%0d]: got %h want 0", i, bus.data_in); end
            n_cmp++; if (bus.instr_in !== 32'h0) begin n_bad++; $display("FAIL clear_instr_in[%0d]: got %h want 0", i, bus.instr_in); end
            n_cmp++; if (bus.bus_error !== 1'b0) begin n_bad++; $display("FAIL clear_err[%0d]: got %b want 0", i, bus.bus_error); end
        end
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_busy(n);
        n_cmp++; if (n != int'(DEPTH)) begin n_bad++; $display("FAIL busy_restart: got %0d want %0d", n, DEPTH); end
        n_cmp++; if (bus.data_in !== 64'h0 || bus.instr_in !== 32'h0) begin n_bad++; $display("FAIL restart_outputs: got %h/%h want 0/0", bus.data_in, bus.instr_in); end
        do_load(BASE + 64'h18);
        n_cmp++; if (bus.data_in !== 64'h0) begin n_bad++; $display("FAIL word_recleared: got %h want 0", bus.data_in); end
    endtask

    task automatic test_below_base();
        do_store(BASE + 64'h78, 64'h5555_5555_5555_5555, 8'hFF);
        do_load(BASE + 64'h78);
        n_cmp++; if (bus.data_in !== 64'h5555_5555_5555_5555) begin n_bad++; $display("FAIL top_word: got %h want 5555555555555555", bus.data_in); end
        n_cmp++; if (bus.bus_error !== 1'b0) begin n_bad++; $display("FAIL err_before_low: got %b want 0", bus.bus_error); end
        do_load(BASE - 64'h8);
        n_cmp++; if (bus.data_in !== 64'h0) begin n_bad++; $display("FAIL low_load: got %h want 0", bus.data_in); end
        n_cmp++; if (bus.bus_error !== 1'b1) begin n_bad++; $display("FAIL low_err: got %b want 1", bus.bus_error); end
        do_store(BASE - 64'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        do_load(BASE + 64'h78);
        n_cmp++; if (bus.data_in !== 64'h5555_5555_5555_5555) begin n_bad++; $display("FAIL low_store_alias: got %h want 5555555555555555", bus.data_in); end
        do_fetch(BASE - 64'h4);
        n_cmp++; if (bus.instr_in !== 32'h0) begin n_bad++; $display("FAIL low_fetch: got %h want 0", bus.instr_in); end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_byte_mask();
        test_fetch();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_clear();
        test_below_base();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
